sram_mp_controller: RTL and testbench
=====================================

# sram_mp_controller

Multi-channel SRAM controller for the SHA-256 accelerator's on-chip memories (message schedule, hash state). Arbitrates up to NUM_CH requestors onto one single-port SRAM with a round-robin arbiter and a valid/ready request handshake. It registers all SRAM-side signals and tracks in-flight reads through a latency pipe, so each read response returns on the issuing channel after a fixed latency.

## Interface
- ADDR_WIDTH, 3: SRAM word-address width.
- DATA_WIDTH, 32: data word width.
- NUM_CH, 2: number of requestor channels, 1..8.
- SRAM_LATENCY, 1: cycles from the cycle `sram_enable`=1 to the cycle `sram_out_data` is valid, 0..4.
- CH_W (localparam): max(1, clog2(NUM_CH)).

Ports:
- clock  in  1  clock; all logic on rising edge.
- reset  in  1  reset, synchronous, active-high.
- req_valid  in  NUM_CH  per-channel request valid.
- req_ready  out  NUM_CH  per-channel grant; handshake when valid&ready.
- req_rw  in  NUM_CH  1=write, 0=read, per channel.
- req_addr  in  NUM_CH*ADDR_WIDTH  packed addresses; channel i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_CH*DATA_WIDTH  packed write data, same packing.
- rsp_valid  out  NUM_CH  one-hot read-response strobe.
- rsp_data  out  DATA_WIDTH  read data, shared by all channels.
- rsp_ch  out  CH_W  channel index of the current response.
- busy  out  1  high while any read is in flight in the latency pipe.
- sram_out_data  in  DATA_WIDTH  SRAM read data.
- sram_enable  out  1  SRAM access strobe.
- sram_rw  out  1  1=write, 0=read.
- sram_addr  out  ADDR_WIDTH  SRAM address.
- sram_write_data  out  DATA_WIDTH  SRAM write data.

## Operation
- Arbiter: rotating priority pointer `ptr` (CH_W bits), reset 0.
  - Grant goes to the first channel with req_valid=1 searching ptr, ptr+1, … mod NUM_CH.
  - req_ready is combinational, one-hot or zero. It is 0 for every channel while reset=1.
  - After a grant to channel g, ptr <= (g+1) mod NUM_CH. With no grant, ptr holds.
- One access is issued per cycle maximum. There is no back-pressure on the SRAM side.
- Issue register: on a grant, sram_enable<=1 and sram_rw/sram_addr/sram_write_data <= the granted channel's fields. With no grant, sram_enable<=0 and the other SRAM outputs hold their last value.
- Latency pipe: a shift register of depth SRAM_LATENCY+1 entries of {valid, ch}.
  - A read grant enters the pipe {1,g}. Writes and idle cycles enter {0,x}.
  - The entry leaving the pipe gates the capture of sram_out_data into rsp_data/rsp_ch.
  - rsp_valid <= onehot(ch) if the entry is valid, else 0. rsp_data and rsp_ch hold when no response.
- Writes produce no response.
- Responses cannot be stalled; requestors must sink rsp_valid every cycle.
- busy = OR of the pipe valid bits and rsp_valid.
- Read-after-write to the same address, issued back-to-back, returns the new data; this relies on the SRAM's write-first ordering.

## Timing
- Handshake at cycle T → sram_enable=1 at T+1.
- Read response at T+2+SRAM_LATENCY (SRAM_LATENCY=1 → T+3). Sustained throughput is 1 access/cycle.
- Reset (any cycle, including mid-operation):
  - sram_enable=0, sram_rw=0, sram_addr=0, sram_write_data=0.
  - rsp_valid=0, rsp_data=0, rsp_ch=0, busy=0, ptr=0.
  - All pipe entries are invalidated; no response for a pre-reset read ever appears.
- First grant possible in the first cycle with reset=0.
- A req_valid that is not granted must be held by the requestor. Its fields may not change until the handshake.
- NUM_CH=1: the arbiter degenerates to req_ready=req_valid; rsp_ch is constant 0.

## Test plan
- Reset check: assert reset mid-burst of 3 reads, SRAM_LATENCY=1 → all outputs 0 next cycle; no rsp_valid in the following 5 cycles.
- Single read: ch0 reads addr 5 with SRAM model returning 0xDEADBEEF → sram_enable/addr=5 at T+1; rsp_valid=2'b01, rsp_data=0xDEADBEEF, rsp_ch=0 at T+3.
- Round-robin: ch0 and ch1 both hold valid for 4 cycles → grants alternate ch0, ch1, ch0, ch1; no channel is granted twice in a row while the other waits.
- Write then read: ch1 writes 0x12345678 to addr 2, then ch0 reads addr 2 next cycle → sram_rw 1 then 0; ch0 receives 0x12345678; the write yields no rsp_valid.
- Streaming: 8 consecutive reads on ch1 to addr 0..7 → 8 consecutive rsp_valid cycles in address order; busy falls the cycle after the last response.
- Latency sweep: SRAM_LATENCY=0 and 3, single read → response at T+2 and T+5 respectively.

Source files
------------

// File: rtl/sram_mp_controller.sv
// sram_mp_controller: round-robin arbiter from NUM_CH requestors onto one
// single-port SRAM, with a latency pipe steering read data to its issuer.
module sram_mp_controller #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH = 2,
  parameter int SRAM_LATENCY = 1,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            req_valid,
  output logic [NUM_CH-1:0]            req_ready,
  input  logic [NUM_CH-1:0]            req_rw,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_CH*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_CH-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]        rsp_data,
  output logic [CH_W-1:0]              rsp_ch,
  output logic                         busy,
  input  logic [DATA_WIDTH-1:0]        sram_out_data,
  output logic                         sram_enable,
  output logic                         sram_rw,
  output logic [ADDR_WIDTH-1:0]        sram_addr,
  output logic [DATA_WIDTH-1:0]        sram_write_data
);
  localparam int CW1 = CH_W + 1;
  localparam logic [CW1-1:0] NCH = CW1'(NUM_CH);
  localparam logic [NUM_CH-1:0] ONE = NUM_CH'(1);
  localparam int LAST = SRAM_LATENCY;

  logic [CH_W-1:0] ptr;
  logic [CH_W-1:0] gnt_idx;
  logic            gnt_any;
  logic            gnt;
  logic            rd_gnt;
  logic [CW1-1:0]  cand;
  logic [CW1-1:0]  nxt;

  // Walk from the farthest offset down so the nearest one to ptr wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + CW1'(k);
      if (cand >= NCH) cand = cand - NCH;
      if (req_valid[cand[CH_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand[CH_W-1:0];
      end
    end
  end

  assign gnt = gnt_any & ~reset;
  assign rd_gnt = gnt & ~req_rw[gnt_idx];
  assign req_ready = gnt ? (ONE << gnt_idx) : '0;
  assign nxt = {1'b0, gnt_idx} + CW1'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr <= '0;
      sram_enable <= 1'b0;
      sram_rw <= 1'b0;
      sram_addr <= '0;
      sram_write_data <= '0;
    end else begin
      sram_enable <= gnt;
      if (gnt) begin
        ptr <= (nxt == NCH) ? '0 : nxt[CH_W-1:0];
        sram_rw <= req_rw[gnt_idx];
        sram_addr <= req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
        sram_write_data <= req_wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  logic [LAST:0]   pv;
  logic [CH_W-1:0] pc [LAST+1];

  always_ff @(posedge clock) begin
    if (reset) begin
      pv <= '0;
    end else begin
      pv[0] <= rd_gnt;
      for (int i = 1; i <= LAST; i++) pv[i] <= pv[i-1];
    end
  end

  always_ff @(posedge clock) begin
    pc[0] <= gnt_idx;
    for (int i = 1; i <= LAST; i++) pc[i] <= pc[i-1];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rsp_valid <= '0;
      rsp_data <= '0;
      rsp_ch <= '0;
    end else begin
      rsp_valid <= pv[LAST] ? (ONE << pc[LAST]) : '0;
      if (pv[LAST]) begin
        rsp_data <= sram_out_data;
        rsp_ch <= pc[LAST];
      end
    end
  end

  assign busy = (|pv) | (|rsp_valid);

endmodule

// File: tb/tb_sram_mp_controller.sv
// tb_sram_mp_controller: directed stimulus shared by three latency variants,
// each checked every cycle against a cycle-indexed response model.
`timescale 1ns/1ps
module tb_sram_mp_controller;
  localparam int AW = 3;
  localparam int DW = 32;
  localparam int NC = 2;
  localparam int NI = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [NC-1:0]    req_valid = '0;
  logic [NC-1:0]    req_rw = '0;
  logic [NC*AW-1:0] req_addr = '0;
  logic [NC*DW-1:0] req_wdata = '0;

  logic [NC-1:0] req_ready [NI];
  logic [NC-1:0] rsp_valid [NI];
  logic [DW-1:0] rsp_data [NI];
  logic [0:0]    rsp_ch [NI];
  logic          busy [NI];
  logic [DW-1:0] sram_out_data [NI];
  logic          sram_enable [NI];
  logic          sram_rw [NI];
  logic [AW-1:0] sram_addr [NI];
  logic [DW-1:0] sram_write_data [NI];

  int applied = 0;
  int miscompares = 0;
  int cyc = 0;

  always #5 clock = ~clock;

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 0 : 3);
  endfunction

  function automatic logic [DW-1:0] init_word(input int a);
    return (a == 5) ? 32'hDEADBEEF : 32'hA5A5_0000 + DW'(a);
  endfunction

  task automatic chk(input string nm, input int inst,
                     input logic [63:0] act, input logic [63:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s inst%0d cyc=%0d got=%0h want=%0h",
               nm, inst, cyc, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int L = (gi == 0) ? 1 : ((gi == 1) ? 0 : 3);
    logic [DW-1:0] mem [8];
    logic [DW-1:0] dly [4];
    logic seeded = 1'b0;

    sram_mp_controller #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
      .NUM_CH(NC), .SRAM_LATENCY(L)
    ) u_dut (
      .clock(clock),
      .reset(reset),
      .req_valid(req_valid),
      .req_ready(req_ready[gi]),
      .req_rw(req_rw),
      .req_addr(req_addr),
      .req_wdata(req_wdata),
      .rsp_valid(rsp_valid[gi]),
      .rsp_data(rsp_data[gi]),
      .rsp_ch(rsp_ch[gi]),
      .busy(busy[gi]),
      .sram_out_data(sram_out_data[gi]),
      .sram_enable(sram_enable[gi]),
      .sram_rw(sram_rw[gi]),
      .sram_addr(sram_addr[gi]),
      .sram_write_data(sram_write_data[gi])
    );

    always @(posedge clock) begin
      if (!seeded) begin
        for (int i = 0; i < 8; i++) mem[i] <= init_word(i);
        seeded <= 1'b1;
      end else if (sram_enable[gi] && sram_rw[gi]) begin
        mem[sram_addr[gi]] <= sram_write_data[gi];
      end
      if (sram_enable[gi]) dly[0] <= mem[sram_addr[gi]];
      for (int i = 1; i < 4; i++) dly[i] <= dly[i-1];
    end

    if (L == 0) begin : g_comb
      assign sram_out_data[gi] = mem[sram_addr[gi]];
    end else begin : g_pipe
      assign sram_out_data[gi] = dly[L-1];
    end
  end

  logic [DW-1:0] m_mem [8];
  int            m_ptr;
  bit            m_ok;
  logic          m_en, m_rw;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wd;
  logic [NC-1:0] m_rv [NI];
  logic [DW-1:0] m_rd [NI];
  int            m_rc [NI];
  logic          m_busy [NI];
  bit            s_v [NI][16];
  int            s_due [NI][16];
  int            s_ch [NI][16];
  logic [DW-1:0] s_d [NI][16];

  initial begin : model
    bit eg_any;
    int eg;
    int a;
    int slot;
    int due;
    logic [NC-1:0] exp_ready;
    for (int i = 0; i < 8; i++) m_mem[i] = init_word(i);
    m_ok = 0;
    m_ptr = 0;
    forever begin
      @(negedge clock);
      eg_any = 0;
      eg = 0;
      if (!reset) begin
        for (int k = 0; k < NC; k++) begin
          if (!eg_any && req_valid[(m_ptr + k) % NC]) begin
            eg_any = 1;
            eg = (m_ptr + k) % NC;
          end
        end
      end
      exp_ready = eg_any ? NC'(1 << eg) : '0;
      for (int i = 0; i < NI; i++) begin
        chk("req_ready", i, req_ready[i], exp_ready);
        if (m_ok) begin
          chk("sram_enable", i, sram_enable[i], m_en);
          chk("sram_rw", i, sram_rw[i], m_rw);
          chk("sram_addr", i, sram_addr[i], m_addr);
          chk("sram_wdata", i, sram_write_data[i], m_wd);
          chk("rsp_valid", i, rsp_valid[i], m_rv[i]);
          chk("rsp_data", i, rsp_data[i], m_rd[i]);
          chk("rsp_ch", i, rsp_ch[i], m_rc[i]);
          chk("busy", i, busy[i], m_busy[i]);
        end
      end
      if (reset) begin
        m_ok = 1;
        m_ptr = 0;
        m_en = 0;
        m_rw = 0;
        m_addr = '0;
        m_wd = '0;
        for (int i = 0; i < NI; i++) begin
          m_rv[i] = '0;
          m_rd[i] = '0;
          m_rc[i] = 0;
          m_busy[i] = 0;
          for (int s = 0; s < 16; s++) s_v[i][s] = 0;
        end
      end else begin
        m_en = eg_any;
        if (eg_any) begin
          a = int'(req_addr[eg*AW +: AW]);
          m_rw = req_rw[eg];
          m_addr = AW'(a);
          m_wd = req_wdata[eg*DW +: DW];
          if (req_rw[eg]) begin
            m_mem[a] = m_wd;
          end else begin
            for (int i = 0; i < NI; i++) begin
              due = cyc + 2 + lat_of(i);
              slot = due % 16;
              s_v[i][slot] = 1;
              s_due[i][slot] = due;
              s_ch[i][slot] = eg;
              s_d[i][slot] = m_mem[a];
            end
          end
          m_ptr = (eg + 1) % NC;
        end
        for (int i = 0; i < NI; i++) begin
          m_rv[i] = '0;
          m_busy[i] = 0;
          for (int s = 0; s < 16; s++) begin
            if (s_v[i][s] && s_due[i][s] == cyc + 1) begin
              m_rv[i] = NC'(1 << s_ch[i][s]);
              m_rd[i] = s_d[i][s];
              m_rc[i] = s_ch[i][s];
              s_v[i][s] = 0;
            end else if (s_v[i][s]) begin
              m_busy[i] = 1;
            end
          end
          if (m_rv[i] != '0) m_busy[i] = 1;
        end
      end
      cyc++;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [NC-1:0] v, input logic [NC-1:0] rw,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    req_valid = v;
    req_rw = rw;
    req_addr = {a1, a0};
    req_wdata = {d1, d0};
  endtask

  task automatic idle();
    drive('0, '0, '0, '0, '0, '0);
  endtask

  initial begin : stim
    repeat (3) step();
    reset = 1'b0;
    drive(2'b11, 2'b00, 3'd1, 3'd3, 32'h0101, 32'h0303);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      if (k == 0) begin
        chk("rst_enable", 0, sram_enable[0], 0);
        chk("rst_busy", 0, busy[0], 0);
        chk("rst_rsp_data", 0, rsp_data[0], 0);
      end
      chk("rr_grant", 0, req_ready[0], (k % 2 == 0) ? 2'b01 : 2'b10);
      step();
    end
    idle();
    repeat (6) step();

    drive(2'b01, 2'b00, 3'd5, 3'd0, 32'h0, 32'h0);
    step();
    idle();
    @(negedge clock);
    chk("rd_enable", 0, sram_enable[0], 1);
    chk("rd_addr", 0, sram_addr[0], 5);
    step();
    @(negedge clock);
    chk("lat0_valid", 1, rsp_valid[1], 2'b01);
    chk("lat0_data", 1, rsp_data[1], 32'hDEADBEEF);
    step();
    @(negedge clock);
    chk("rd_valid", 0, rsp_valid[0], 2'b01);
    chk("rd_data", 0, rsp_data[0], 32'hDEADBEEF);
    chk("rd_ch", 0, rsp_ch[0], 0);
    chk("lat3_early", 2, rsp_valid[2], 0);
    step();
    step();
    @(negedge clock);
    chk("lat3_valid", 2, rsp_valid[2], 2'b01);
    chk("lat3_data", 2, rsp_data[2], 32'hDEADBEEF);
    repeat (3) step();

    drive(2'b10, 2'b10, 3'd0, 3'd2, 32'h0, 32'h12345678);
    step();
    drive(2'b01, 2'b00, 3'd2, 3'd0, 32'h0, 32'h0);
    @(negedge clock);
    chk("wr_rw", 0, sram_rw[0], 1);
    chk("wr_data", 0, sram_write_data[0], 32'h12345678);
    chk("raw_grant", 0, req_ready[0], 2'b01);
    step();
    idle();
    @(negedge clock);
    chk("raw_rw", 0, sram_rw[0], 0);
    chk("raw_addr", 0, sram_addr[0], 2);
    step();
    @(negedge clock);
    chk("wr_no_rsp", 0, rsp_valid[0], 0);
    step();
    @(negedge clock);
    chk("raw_valid", 0, rsp_valid[0], 2'b01);
    chk("raw_data", 0, rsp_data[0], 32'h12345678);
    repeat (4) step();

    for (int i = 0; i < 8; i++) begin
      drive(2'b10, 2'b00, 3'd0, AW'(i), 32'h0, 32'hC0DE_0000 + DW'(i));
      if (i == 3) begin
        @(negedge clock);
        chk("st_first_v", 0, rsp_valid[0], 2'b10);
        chk("st_first_d", 0, rsp_data[0], 32'hA5A5_0000);
      end
      if (i == 5) begin
        @(negedge clock);
        chk("st_raw_d", 0, rsp_data[0], 32'h12345678);
      end
      step();
    end
    idle();
    step();
    step();
    @(negedge clock);
    chk("st_last_v", 0, rsp_valid[0], 2'b10);
    chk("st_last_d", 0, rsp_data[0], 32'hA5A5_0007);
    chk("st_last_busy", 0, busy[0], 1);
    step();
    @(negedge clock);
    chk("st_idle_v", 0, rsp_valid[0], 0);
    chk("st_idle_busy", 0, busy[0], 0);
    repeat (2) step();

    drive(2'b01, 2'b00, 3'd0, 3'd0, 32'h0, 32'h0);
    step();
    drive(2'b01, 2'b00, 3'd1, 3'd0, 32'h0, 32'h0);
    step();
    drive(2'b01, 2'b00, 3'd3, 3'd0, 32'h0, 32'h0);
    reset = 1'b1;
    @(negedge clock);
    chk("rst_ready", 0, req_ready[0], 0);
    step();
    reset = 1'b0;
    idle();
    @(negedge clock);
    for (int i = 0; i < NI; i++) begin
      chk("mid_rst_en", i, sram_enable[i], 0);
      chk("mid_rst_addr", i, sram_addr[i], 0);
      chk("mid_rst_rv", i, rsp_valid[i], 0);
      chk("mid_rst_busy", i, busy[i], 0);
    end
    for (int j = 0; j < 5; j++) begin
      step();
      @(negedge clock);
      for (int i = 0; i < NI; i++) chk("post_rst_rv", i, rsp_valid[i], 0);
    end
    step();

    drive(2'b11, 2'b00, 3'd4, 3'd6, 32'h0, 32'h0);
    @(negedge clock);
    chk("ptr_rst", 0, req_ready[0], 2'b01);
    step();
    drive(2'b10, 2'b00, 3'd4, 3'd6, 32'h0, 32'h0);
    @(negedge clock);
    chk("ptr_next", 0, req_ready[0], 2'b10);
    step();
    idle();
    repeat (6) step();

    $display("== %0d vectors applied, %0d miscompares ==",
             applied, miscompares);
    $finish;
  end

endmodule
